// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences LDI / MOV / SWAP / RD commands onto an external
// register file with one write port and one combinational read port.
module regfile_ctrl #(
  parameter int k = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s,
  input  logic [1:0]   op,
  input  logic [2:0]   rd,
  input  logic [2:0]   rs,
  input  logic [k-1:0] imm,
  input  logic [k-1:0] rf_data_out,
  output logic [k-1:0] rf_data_in,
  output logic [2:0]   rf_writenum,
  output logic [2:0]   rf_readnum,
  output logic         rf_write,
  output logic         w,
  output logic         done,
  output logic [k-1:0] result
);

  typedef enum logic [3:0] {
    WAIT, LDI, MOV_R, MOV_W, SW_RA, SW_RB, SW_WA, SW_WB, RD_R, DONE
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   rd_q, rd_d, rs_q, rs_d;
  logic [k-1:0] imm_q, imm_d;
  logic [k-1:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic [k-1:0] result_q, result_d;

  // Output flops are loaded with the decode of the next state, so each
  // output is a clean register that is valid for the whole state it belongs to.
  logic         rf_write_q, rf_write_d;
  logic [2:0]   rf_writenum_q, rf_writenum_d;
  logic [2:0]   rf_readnum_q, rf_readnum_d;
  logic [k-1:0] rf_data_in_q, rf_data_in_d;
  logic         w_q, w_d;
  logic         done_q, done_d;

  // Next-state, command latching and read-data capture.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    imm_d    = imm_q;
    tmp_a_d  = tmp_a_q;
    tmp_b_d  = tmp_b_q;
    result_d = result_q;
    case (state_q)
      WAIT: begin
        if (s) begin
          rd_d  = rd;
          rs_d  = rs;
          imm_d = imm;
          case (op)
            2'b00:   state_d = LDI;
            2'b01:   state_d = MOV_R;
            2'b10:   state_d = SW_RA;
            default: state_d = RD_R;
          endcase
        end
      end
      LDI:   state_d = DONE;
      MOV_R: begin
        tmp_a_d = rf_data_out;
        state_d = MOV_W;
      end
      MOV_W: state_d = DONE;
      SW_RA: begin
        tmp_a_d = rf_data_out;
        state_d = SW_RB;
      end
      SW_RB: begin
        tmp_b_d = rf_data_out;
        state_d = SW_WA;
      end
      SW_WA: state_d = SW_WB;
      SW_WB: state_d = DONE;
      RD_R: begin
        result_d = rf_data_out;
        state_d  = DONE;
      end
      DONE:    state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // Moore output decode of the state being entered, using the values the
  // command and temporary registers will hold in that state.
  always_comb begin
    rf_write_d    = 1'b0;
    rf_writenum_d = '0;
    rf_readnum_d  = '0;
    rf_data_in_d  = '0;
    w_d           = (state_d == WAIT);
    done_d        = (state_d == DONE);
    case (state_d)
      LDI: begin
        rf_write_d    = 1'b1;
        rf_writenum_d = rd_d;
        rf_data_in_d  = imm_d;
      end
      MOV_R: rf_readnum_d = rs_d;
      MOV_W: begin
        rf_write_d    = 1'b1;
        rf_writenum_d = rd_d;
        rf_data_in_d  = tmp_a_d;
      end
      SW_RA: rf_readnum_d = rd_d;
      SW_RB: rf_readnum_d = rs_d;
      SW_WA: begin
        rf_write_d    = 1'b1;
        rf_writenum_d = rd_d;
        rf_data_in_d  = tmp_b_d;
      end
      SW_WB: begin
        rf_write_d    = 1'b1;
        rf_writenum_d = rs_d;
        rf_data_in_d  = tmp_a_d;
      end
      RD_R:    rf_readnum_d = rs_d;
      default: ;
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT;
      rd_q          <= '0;
      rs_q          <= '0;
      imm_q         <= '0;
      tmp_a_q       <= '0;
      tmp_b_q       <= '0;
      result_q      <= '0;
      rf_write_q    <= 1'b0;
      rf_writenum_q <= '0;
      rf_readnum_q  <= '0;
      rf_data_in_q  <= '0;
      w_q           <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      rs_q          <= rs_d;
      imm_q         <= imm_d;
      tmp_a_q       <= tmp_a_d;
      tmp_b_q       <= tmp_b_d;
      result_q      <= result_d;
      rf_write_q    <= rf_write_d;
      rf_writenum_q <= rf_writenum_d;
      rf_readnum_q  <= rf_readnum_d;
      rf_data_in_q  <= rf_data_in_d;
      w_q           <= w_d;
      done_q        <= done_d;
    end
  end

  // A reset arriving on the same edge as a pending write must abort that
  // write too, so the registered enable is masked by reset.
  assign rf_write    = rf_write_q & ~reset;
  assign rf_writenum = rf_writenum_q;
  assign rf_readnum  = rf_readnum_q;
  assign rf_data_in  = rf_data_in_q;
  assign w           = w_q;
  assign done        = done_q;
  assign result      = result_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: drives commands into regfile_ctrl attached to a behavioural
// register file and compares against an array-based reference model.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [1:0]  op;
  logic [2:0]  rd, rs;
  logic [15:0] imm;
  logic [15:0] rf_data_out, rf_data_in, result;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write, w, done;

  logic [15:0] rf [8];
  logic [15:0] ref_rf [8];
  logic [15:0] ref_result;
  int total = 0;
  int bad = 0;

  regfile_ctrl #(.k(16)) dut (
    .clk(clk), .reset(reset), .s(s), .op(op), .rd(rd), .rs(rs), .imm(imm),
    .rf_data_out(rf_data_out), .rf_data_in(rf_data_in),
    .rf_writenum(rf_writenum), .rf_readnum(rf_readnum),
    .rf_write(rf_write), .w(w), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Behavioural register file: synchronous write, combinational read.
  always @(posedge clk) if (rf_write) rf[rf_writenum] <= rf_data_in;
  assign rf_data_out = rf[rf_readnum];

  function automatic int exp_lat(input logic [1:0] o);
    case (o)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 5;
      default: return 2;
    endcase
  endfunction

  // Issue one command, measure accept-to-done latency and write count, and
  // apply the command's effect to the reference model once it completes.
  task automatic run_cmd(input logic [1:0] o, input logic [2:0] d, input logic [2:0] r,
                         input logic [15:0] im, input bit junk,
                         output int lat, output int nw);
    logic [15:0] t;
    @(negedge clk);
    s = 1'b1; op = o; rd = d; rs = r; imm = im;
    @(posedge clk);
    lat = 0;
    nw = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rf_write === 1'b1) nw++;
      if (done === 1'b1) begin
        lat = c;
        s = 1'b0;
        break;
      end
      if (junk) begin
        s = 1'b1; op = ~o; rd = ~d; rs = d + 3'd1; imm = ~im;
      end else begin
        s = 1'b0;
      end
    end
    s = 1'b0;
    if (lat != 0) begin
      case (o)
        2'b00: ref_rf[d] = im;
        2'b01: ref_rf[d] = ref_rf[r];
        2'b10: begin
          t = ref_rf[d];
          ref_rf[d] = ref_rf[r];
          ref_rf[r] = t;
        end
        default: ref_result = ref_rf[r];
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; op = '0; rd = '0; rs = '0; imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (w !== 1'b1 || done !== 1'b0 || rf_write !== 1'b0 || result !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: w=%b done=%b rf_write=%b result=%h, required 1 0 0 0000",
               w, done, rf_write, result);
    end
    total++;
    if (rf_readnum !== 3'd0 || rf_writenum !== 3'd0 || rf_data_in !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_ports: readnum=%0d writenum=%0d data_in=%h, required 0 0 0000",
               rf_readnum, rf_writenum, rf_data_in);
    end
    reset = 1'b0;
    ref_result = 16'h0;
  endtask

  task automatic test_ldi();
    int lat, nw;
    for (int i = 0; i < 8; i++) run_cmd(2'b00, 3'(i), 3'd0, 16'($urandom), 1'b0, lat, nw);
    run_cmd(2'b00, 3'd3, 3'd0, 16'hBEEF, 1'b0, lat, nw);
    total++;
    if (rf[3] !== 16'hBEEF) begin
      bad++; $display("[TB] FAIL ldi_value: R3=%h, required BEEF", rf[3]);
    end
    total++;
    if (lat != 2 || nw != 1) begin
      bad++; $display("[TB] FAIL ldi_timing: latency=%0d writes=%0d, required 2 1", lat, nw);
    end
    @(negedge clk);
    total++;
    if (w !== 1'b1 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL ldi_idle: w=%b done=%b, required 1 0", w, done);
    end
  endtask

  task automatic test_mov();
    int lat, nw;
    run_cmd(2'b00, 3'd1, 3'd0, 16'h1234, 1'b0, lat, nw);
    run_cmd(2'b01, 3'd5, 3'd1, 16'h0, 1'b0, lat, nw);
    total++;
    if (rf[5] !== 16'h1234 || rf[1] !== 16'h1234) begin
      bad++; $display("[TB] FAIL mov_value: R5=%h R1=%h, required 1234 1234", rf[5], rf[1]);
    end
    total++;
    if (lat != 3 || nw != 1) begin
      bad++; $display("[TB] FAIL mov_timing: latency=%0d writes=%0d, required 3 1", lat, nw);
    end
  endtask

  task automatic test_swap();
    int lat, nw;
    run_cmd(2'b00, 3'd2, 3'd0, 16'h00AA, 1'b0, lat, nw);
    run_cmd(2'b00, 3'd6, 3'd0, 16'h5500, 1'b0, lat, nw);
    run_cmd(2'b10, 3'd2, 3'd6, 16'h0, 1'b0, lat, nw);
    total++;
    if (rf[2] !== 16'h5500 || rf[6] !== 16'h00AA) begin
      bad++; $display("[TB] FAIL swap_value: R2=%h R6=%h, required 5500 00AA", rf[2], rf[6]);
    end
    total++;
    if (lat != 5 || nw != 2) begin
      bad++; $display("[TB] FAIL swap_timing: latency=%0d writes=%0d, required 5 2", lat, nw);
    end
  endtask

  task automatic test_rd();
    int lat, nw;
    run_cmd(2'b11, 3'd0, 3'd6, 16'h0, 1'b0, lat, nw);
    total++;
    if (result !== 16'h00AA || lat != 2 || nw != 0) begin
      bad++;
      $display("[TB] FAIL rd_value: result=%h latency=%0d writes=%0d, required 00AA 2 0",
               result, lat, nw);
    end
    run_cmd(2'b00, 3'd6, 3'd0, 16'h7777, 1'b0, lat, nw);
    total++;
    if (result !== 16'h00AA || rf[6] !== 16'h7777) begin
      bad++;
      $display("[TB] FAIL rd_hold: result=%h R6=%h, required 00AA 7777", result, rf[6]);
    end
  endtask

  task automatic test_ignore();
    int lat, nw;
    logic [15:0] r4;
    run_cmd(2'b00, 3'd2, 3'd0, 16'h0A0A, 1'b0, lat, nw);
    run_cmd(2'b00, 3'd6, 3'd0, 16'h6060, 1'b0, lat, nw);
    run_cmd(2'b10, 3'd2, 3'd6, 16'hFFFF, 1'b1, lat, nw);
    total++;
    if (rf[2] !== 16'h6060 || rf[6] !== 16'h0A0A || lat != 5 || nw != 2) begin
      bad++;
      $display("[TB] FAIL ignore_s: R2=%h R6=%h latency=%0d writes=%0d, required 6060 0A0A 5 2",
               rf[2], rf[6], lat, nw);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rf[i] !== ref_rf[i]) begin
        bad++; $display("[TB] FAIL ignore_regs: R%0d=%h, required %h", i, rf[i], ref_rf[i]);
      end
    end
    r4 = ref_rf[4];
    run_cmd(2'b10, 3'd4, 3'd4, 16'h0, 1'b0, lat, nw);
    total++;
    if (rf[4] !== r4 || lat != 5) begin
      bad++;
      $display("[TB] FAIL swap_same: R4=%h latency=%0d, required %h 5", rf[4], lat, r4);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nw;
    run_cmd(2'b00, 3'd2, 3'd0, 16'h1111, 1'b0, lat, nw);
    run_cmd(2'b00, 3'd6, 3'd0, 16'h2222, 1'b0, lat, nw);
    @(negedge clk);
    s = 1'b1; op = 2'b10; rd = 3'd2; rs = 3'd6; imm = 16'h0;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_rf[2] = 16'h2222;
    ref_result = 16'h0;
    total++;
    if (rf[2] !== 16'h2222 || rf[6] !== 16'h2222) begin
      bad++;
      $display("[TB] FAIL reset_abort_regs: R2=%h R6=%h, required 2222 2222", rf[2], rf[6]);
    end
    total++;
    if (w !== 1'b1 || done !== 1'b0 || result !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_abort_state: w=%b done=%b result=%h, required 1 0 0000",
               w, done, result);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rf[i] !== ref_rf[i]) begin
        bad++; $display("[TB] FAIL reset_keep_regs: R%0d=%h, required %h", i, rf[i], ref_rf[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, nw;
    logic [1:0] o;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom);
      run_cmd(o, 3'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), lat, nw);
      total++;
      if (lat != exp_lat(o)) begin
        bad++;
        $display("[TB] FAIL rand_latency: op=%0d latency=%0d, required %0d", o, lat, exp_lat(o));
      end
      total++;
      if (result !== ref_result) begin
        bad++; $display("[TB] FAIL rand_result: result=%h, required %h", result, ref_result);
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rf[i] !== ref_rf[i]) begin
          bad++; $display("[TB] FAIL rand_regs: R%0d=%h, required %h", i, rf[i], ref_rf[i]);
        end
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || w !== 1'b1) begin
        bad++; $display("[TB] FAIL rand_done_pulse: done=%b w=%b, required 0 1", done, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_swap();
    test_rd();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
